control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port iRun, input, 1 bit: start request; sampled only in state T0.
REQ-004 SHALL have port iIns, input, 9 bits: instruction register contents {III opcode [8:6], XXX [5:3], YYY [2:0]} from the datapath frame.
REQ-005 SHALL have port oIR, output, 1 bit: instruction-register load enable.
REQ-006 SHALL have port oEn, output, 8 bits: one-hot write enables for R7..R0 (bit n = Rn).
REQ-007 SHALL have port oMux, output, 10 bits: one-hot bus select {DINout[9], Gout[8], R7..R0[7:0]}; all-zero when the bus is idle.
REQ-008 SHALL have port oALU, output, 3 bits: {Ain[2], Gin[1], AddSub[0]}; AddSub 1 = subtract.
REQ-009 SHALL have port oDone, output, 1 bit: one-cycle pulse in the final cycle of each instruction.
REQ-010 SHALL have port oInsCnt, output, 8 bits: count of completed instructions.

Function
REQ-011 SHALL implement FSM states T0, T1, T2, T3; all control outputs are combinational decodes of the current state and iIns.
REQ-012 T0: oIR = iRun, all other controls 0; next state T1 if iRun = 1, else T0.
REQ-013 Opcode 000 (mv Rx,Ry), T1: oMux bit YYY = 1, oEn bit XXX = 1, oDone = 1; next T0.
REQ-014 Opcode 001 (mvi Rx,#D), T1: oMux[9] = 1, oEn bit XXX = 1, oDone = 1; next T0; immediate is valid on DIN during this cycle.
REQ-015 Opcodes 010 (add) and 011 (sub), T1: oMux bit XXX = 1, oALU[2] = 1; next T2.
REQ-016 add/sub, T2: oMux bit YYY = 1, oALU[1] = 1, oALU[0] = iIns[6]; next T3.
REQ-017 add/sub, T3: oMux[8] = 1, oEn bit XXX = 1, oDone = 1; next T0.
REQ-018 Opcodes 100..111, T1: no enables, oMux = 0, oDone = 1; next T0 (NOP).
REQ-019 Latency: mv/mvi/NOP = 2 cycles, add/sub = 4 cycles, counted from T0 with iRun = 1 through oDone.
REQ-020 iRun SHALL be ignored in T1..T3; back-to-back instructions SHALL be accepted when iRun = 1 in the T0 following oDone.
REQ-021 At most one bit of oMux and at most one bit of oEn SHALL be 1 in any cycle.
REQ-022 oInsCnt SHALL increment by 1 on each clock edge where oDone = 1, wrapping 255 -> 0.
REQ-023 XXX = YYY SHALL be legal: mv R3,R3 rewrites R3, and add R2,R2 doubles R2.

Reset
REQ-024 With iRst = 1 at a clock edge: state becomes T0 and oInsCnt becomes 0, regardless of the current state.
REQ-025 Reset mid-instruction (T1..T3) SHALL abort it with no further register write, no oDone, and no counter increment.
REQ-026 After reset, with iRun = 0: oIR, oEn, oMux, oALU and oDone are all 0, and oInsCnt = 0.

Configuration
REQ-027 With macro CTRL_ILLEGAL_EN defined, the block SHALL add output oIllegal (1 bit), which is 1 in T1 for opcodes 100..111 together with oDone, and 0 otherwise.
REQ-028 Without CTRL_ILLEGAL_EN, port oIllegal SHALL be absent, and opcodes 100..111 behave per REQ-018 only.

Verification
REQ-029 Reset, then hold iRun = 0 for 5 cycles -> state stays T0, all controls 0, oInsCnt = 0.
REQ-030 iRun = 1, iIns = 001_010_000 (mvi R2) -> T0: oIR = 1; T1: oMux = 10'h200, oEn = 8'h04, oDone = 1; oInsCnt = 1.
REQ-031 iIns = 011_001_101 (sub R1,R5) -> T1: oMux = 10'h002, oALU = 3'b100; T2: oMux = 10'h020, oALU = 3'b011; T3: oMux = 10'h100, oEn = 8'h02, oDone = 1.
REQ-032 iIns = 010_000_000 (add R0,R0) with iRst = 1 during T2 -> next cycle T0, no oEn pulse, no oDone, oInsCnt = 0.
REQ-033 Issue 256 mv instructions back-to-back -> oDone pulses every second cycle, and oInsCnt wraps to 0 after the 256th.
REQ-034 iIns = 110_011_011 -> T1: oEn = 0, oMux = 0, oDone = 1; oIllegal = 1 only with CTRL_ILLEGAL_EN defined.

Source files
------------

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Four-state control FSM (T0..T3) for a small eight-register processor.
// It steps through one instruction at a time. All control outputs are
// combinational decodes of the current state and the instruction word.
// A counter tracks how many instructions have completed.
//
// Instruction word iIns = {opcode[8:6], XXX[5:3], YYY[2:0]}
//   000 mv  Rx,Ry   : T1 Ry -> Rx, done
//   001 mvi Rx,#D   : T1 DIN -> Rx, done
//   010 add Rx,Ry   : T1 Rx -> A, T2 Ry + A -> G, T3 G -> Rx, done
//   011 sub Rx,Ry   : as add, with AddSub = 1 in T2
//   1xx             : no-op, done in T1
//
// Ports
//   iClk      in   1  clock, rising edge
//   iRst      in   1  synchronous active-high reset
//   iRun      in   1  start request, sampled only in T0
//   iIns      in   9  instruction register contents
//   oIR       out  1  instruction-register load enable
//   oEn       out  8  one-hot register write enables, bit n = Rn
//   oMux      out 10  one-hot bus select {DINout, Gout, R7..R0}
//   oALU      out  3  {Ain, Gin, AddSub}, AddSub 1 = subtract
//   oDone     out  1  pulse in the last cycle of each instruction
//   oInsCnt   out  8  completed-instruction count, wraps 255 -> 0
//   oIllegal  out  1  only when CTRL_ILLEGAL_EN is defined: high with
//                     oDone in T1 for opcodes 100..111
//
// Build option: define CTRL_ILLEGAL_EN to add the oIllegal output.
// -----------------------------------------------------------------------------
module control_unit (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRun,
    input  logic [8:0] iIns,
    output logic       oIR,
    output logic [7:0] oEn,
    output logic [9:0] oMux,
    output logic [2:0] oALU,
    output logic       oDone,
    output logic [7:0] oInsCnt
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic       oIllegal
`endif
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [9:0] MUX_DIN = 10'h200;
    localparam logic [9:0] MUX_G   = 10'h100;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] ins_cnt_reg;
    logic [7:0] ins_cnt_next;

    logic [2:0] opcode;
    logic [2:0] reg_x;
    logic [2:0] reg_y;
    logic [7:0] x_onehot;
    logic [7:0] y_onehot;

    logic       ir_dec;
    logic [7:0] en_dec;
    logic [9:0] mux_dec;
    logic [2:0] alu_dec;
    logic       done_dec;
`ifdef CTRL_ILLEGAL_EN
    logic       illegal_dec;
`endif

    assign opcode = iIns[8:6];
    assign reg_x  = iIns[5:3];
    assign reg_y  = iIns[2:0];

    // One-hot register decoders for the XXX and YYY fields.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg_dec
            assign x_onehot[gi] = (reg_x == 3'(gi));
            assign y_onehot[gi] = (reg_y == 3'(gi));
        end
    endgenerate

    // Next-state and control decode.
    always_comb begin
        state_next = state_reg;
        ir_dec     = 1'b0;
        en_dec     = 8'h00;
        mux_dec    = 10'h000;
        alu_dec    = 3'b000;
        done_dec   = 1'b0;
`ifdef CTRL_ILLEGAL_EN
        illegal_dec = 1'b0;
`endif
        case (state_reg)
            T0: begin
                ir_dec = iRun;
                if (iRun) begin
                    state_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        mux_dec    = {2'b00, y_onehot};
                        en_dec     = x_onehot;
                        done_dec   = 1'b1;
                        state_next = T0;
                    end
                    OP_MVI: begin
                        // The immediate sits on DIN during this cycle.
                        mux_dec    = MUX_DIN;
                        en_dec     = x_onehot;
                        done_dec   = 1'b1;
                        state_next = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        mux_dec    = {2'b00, x_onehot};
                        alu_dec    = 3'b100;
                        state_next = T2;
                    end
                    default: begin
                        // Unused opcodes complete as a one-step no-op.
                        done_dec   = 1'b1;
                        state_next = T0;
`ifdef CTRL_ILLEGAL_EN
                        illegal_dec = 1'b1;
`endif
                    end
                endcase
            end
            T2: begin
                // opcode[0] separates sub (011) from add (010).
                mux_dec    = {2'b00, y_onehot};
                alu_dec    = {1'b0, 1'b1, iIns[6]};
                state_next = T3;
            end
            T3: begin
                mux_dec    = MUX_G;
                en_dec     = x_onehot;
                done_dec   = 1'b1;
                state_next = T0;
            end
            default: begin
                state_next = T0;
            end
        endcase
    end

    assign ins_cnt_next = done_dec ? (ins_cnt_reg + 8'd1) : ins_cnt_reg;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg   <= T0;
            ins_cnt_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            ins_cnt_reg <= ins_cnt_next;
        end
    end

    // A reset that lands in the middle of an instruction aborts it. The
    // write, load and completion strobes are suppressed in that cycle, so the
    // aborted instruction does not write a register or report completion.
    // Bus and ALU selects only steer data and cannot change state, so they
    // are not gated.
    assign oIR     = ir_dec & ~iRst;
    assign oEn     = iRst ? 8'h00 : en_dec;
    assign oMux    = mux_dec;
    assign oALU    = alu_dec;
    assign oDone   = done_dec & ~iRst;
    assign oInsCnt = ins_cnt_reg;
`ifdef CTRL_ILLEGAL_EN
    assign oIllegal = illegal_dec & ~iRst;
`endif

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Scoreboard bench for control_unit. For every cycle it drives, the stimulus
// side pushes the expected outputs into a queue. The expected values come
// from an instruction-level model: each instruction is a list of phases built
// from the opcode rules. A monitor on the falling edge pops one entry per
// driven cycle. It compares that entry with the DUT outputs and also checks
// that oEn and oMux are never more than one-hot.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       iClk;
    logic       iRst;
    logic       iRun;
    logic [8:0] iIns;
    logic       oIR;
    logic [7:0] oEn;
    logic [9:0] oMux;
    logic [2:0] oALU;
    logic       oDone;
    logic [7:0] oInsCnt;
`ifdef CTRL_ILLEGAL_EN
    logic       oIllegal;
`endif

    control_unit dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iRun    (iRun),
        .iIns    (iIns),
        .oIR     (oIR),
        .oEn     (oEn),
        .oMux    (oMux),
        .oALU    (oALU),
        .oDone   (oDone),
        .oInsCnt (oInsCnt)
`ifdef CTRL_ILLEGAL_EN
        ,
        .oIllegal(oIllegal)
`endif
    );

    typedef struct packed {
        logic       ir;
        logic [7:0] en;
        logic [9:0] mux;
        logic [2:0] alu;
        logic       done;
        logic       ill;
        logic [7:0] cnt;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    fails  = 0;
    logic [7:0] model_cnt = 8'h00;

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // ---------------- reference model ----------------
    function automatic int n_phases(input logic [8:0] ins);
        return (ins[8:6] == 3'b010 || ins[8:6] == 3'b011) ? 4 : 2;
    endfunction

    // Expected controls for phase p (0 = T0) of an instruction.
    function automatic exp_t phase_rec(input logic [8:0] ins, input int p);
        exp_t e;
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        e  = '0;
        op = ins[8:6];
        x  = ins[5:3];
        y  = ins[2:0];
        if (p == 0) begin
            e.ir = 1'b1;
        end else if (op == 3'b000) begin
            e.mux[y] = 1'b1; e.en[x] = 1'b1; e.done = 1'b1;
        end else if (op == 3'b001) begin
            e.mux[9] = 1'b1; e.en[x] = 1'b1; e.done = 1'b1;
        end else if (op[2] == 1'b0) begin
            if (p == 1) begin
                e.mux[x] = 1'b1; e.alu = 3'b100;
            end else if (p == 2) begin
                e.mux[y] = 1'b1; e.alu = {2'b01, op[0]};
            end else begin
                e.mux[8] = 1'b1; e.en[x] = 1'b1; e.done = 1'b1;
            end
        end else begin
            e.done = 1'b1;
`ifdef CTRL_ILLEGAL_EN
            e.ill = 1'b1;
`endif
        end
        return e;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input logic run, input logic rst, input logic [8:0] ins,
                         input exp_t e, input string tag);
        iRun = run;
        iRst = rst;
        iIns = ins;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge iClk);
        #1;
    endtask

    task automatic idle(input logic rst, input string tag);
        exp_t e;
        e     = '0;
        e.cnt = model_cnt;
        drive(1'b0, rst, 9'($urandom), e, tag);
        if (rst) model_cnt = 8'h00;
    endtask

    // abort_phase 0 = run to completion, else assert reset in that phase.
    task automatic issue(input logic [8:0] ins, input int abort_phase, input string tag);
        exp_t e;
        logic rst;
        logic run;
        for (int p = 0; p < n_phases(ins); p++) begin
            e     = phase_rec(ins, p);
            e.cnt = model_cnt;
            rst   = (abort_phase != 0) && (p == abort_phase);
            run   = (p == 0) ? 1'b1 : 1'($urandom);
            if (rst) begin
                e.ir = 1'b0; e.en = 8'h00; e.done = 1'b0; e.ill = 1'b0;
            end
            drive(run, rst, ins, e, $sformatf("%s ins=%b p%0d", tag, ins, p));
            if (rst) begin
                model_cnt = 8'h00;
                return;
            end
            if (e.done) model_cnt = model_cnt + 8'd1;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t  exp_v;
        exp_t  act;
        string tag;
        forever begin
            @(negedge iClk);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                tag   = tag_q.pop_front();
                act.ir   = oIR;
                act.en   = oEn;
                act.mux  = oMux;
                act.alu  = oALU;
                act.done = oDone;
`ifdef CTRL_ILLEGAL_EN
                act.ill  = oIllegal;
`else
                act.ill  = 1'b0;
`endif
                act.cnt  = oInsCnt;
                checks++;
                if (act !== exp_v || $countones(oEn) > 1 || $countones(oMux) > 1) begin
                    fails++;
                    $display("FAIL %s: got ir=%b en=%h mux=%h alu=%b done=%b ill=%b cnt=%0d, want ir=%b en=%h mux=%h alu=%b done=%b ill=%b cnt=%0d",
                             tag, act.ir, act.en, act.mux, act.alu, act.done, act.ill, act.cnt,
                             exp_v.ir, exp_v.en, exp_v.mux, exp_v.alu, exp_v.done, exp_v.ill, exp_v.cnt);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int ab;
        iRst = 1'b1;
        iRun = 1'b0;
        iIns = 9'h000;
        @(posedge iClk);
        #1;
        idle(1'b1, "reset");
        repeat (5) idle(1'b0, "idle after reset");

        issue(9'b001_010_000, 0, "mvi R2");
        issue(9'b011_001_101, 0, "sub R1,R5");
        issue(9'b010_000_000, 2, "add R0,R0 reset in T2");
        idle(1'b0, "after abort");
        issue(9'b110_011_011, 0, "nop opcode 110");
        issue(9'b000_011_011, 0, "mv R3,R3");
        issue(9'b010_010_010, 0, "add R2,R2");

        // Clear the count, then 256 back-to-back moves must wrap it to 0.
        idle(1'b1, "reset before wrap");
        for (int i = 0; i < 256; i++) begin
            issue({3'b000, 6'($urandom)}, 0, $sformatf("mv #%0d", i));
        end
        idle(1'b0, "count after wrap");

        for (int i = 0; i < 150; i++) begin
            logic [8:0] ins;
            ins = 9'($urandom);
            n   = n_phases(ins);
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, n - 1)) : 0;
            repeat ($urandom_range(0, 2)) idle(1'b0, "random gap");
            if ($urandom_range(0, 19) == 0) idle(1'b1, "random idle reset");
            issue(ins, ab, $sformatf("rand #%0d", i));
        end
        idle(1'b0, "final idle");

        for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(posedge iClk);
        if (sb_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
